// File: rtl/mem_port_arbiter.sv
// Shares the core memory port between fetch (IF) and the LSU, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT watchdog and the sticky timeout_o output.
module mem_port_arbiter #(
    parameter int unsigned MAX_LSU_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_rsp_valid_o,
    output logic [31:0] ifu_rsp_data_o,
    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wen_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [2:0]  lsu_load_type_i,
    input  logic [2:0]  lsu_store_type_i,
    output logic        lsu_rsp_valid_o,
    output logic [31:0] lsu_rsp_data_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_e;

    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_H  = 3'd2;
    localparam logic [2:0] LOAD_BU = 3'd5;
    localparam logic [2:0] LOAD_HU = 3'd6;
    localparam logic [2:0] STORE_B = 3'd1;
    localparam logic [2:0] STORE_H = 3'd2;
    localparam logic [2:0] STORE_W = 3'd3;
    localparam logic [2:0] STORE_D = 3'd4;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

    function automatic logic [3:0] store_strb(input logic [2:0] stype, input logic [1:0] off);
        logic [3:0] strb;
        case (stype)
            STORE_B:          strb = 4'b0001 << off;
            STORE_H:          strb = 4'b0011 << off;
            STORE_W, STORE_D: strb = 4'b1111;
            default:          strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] stype, input logic [31:0] wdata);
        logic [31:0] d;
        case (stype)
            STORE_B: d = {4{wdata[7:0]}};
            STORE_H: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] ltype, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (ltype)
            LOAD_B:  r = {{24{b[7]}}, b};
            LOAD_BU: r = {24'd0, b};
            LOAD_H:  r = {{16{h[15]}}, h};
            LOAD_HU: r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e      state_q;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic        owner_lsu_q;
    logic [1:0]  off_q;
    logic [2:0]  load_type_q;
    logic        wen_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        ifu_rsp_valid_q;
    logic        lsu_rsp_valid_q;
    logic [31:0] ifu_rsp_data_q;
    logic [31:0] lsu_rsp_data_q;
    logic        grant_ifu;
    logic        grant_lsu;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_q;
`endif

    // Grant decision; gated by rst_n so no ready is offered while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (lsu_req_valid_i && ifu_req_valid_i) begin
                if (streak_q == STREAK_MAX) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (lsu_req_valid_i) begin
                grant_lsu = 1'b1;
            end else if (ifu_req_valid_i) begin
                grant_ifu = 1'b1;
            end else begin
                grant_ifu = 1'b0;
            end
        end else begin
            grant_ifu = 1'b0;
        end
    end

    // Anti-starvation streak: counts LSU wins only while IF is left waiting.
    always_comb begin
        streak_d = streak_q;
        if (grant_lsu) begin
            if (ifu_req_valid_i) begin
                streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end else if (grant_ifu) begin
            streak_d = 4'd0;
        end else begin
            streak_d = streak_q;
        end
    end

    // Transaction FSM with latched request fields and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            streak_q        <= 4'd0;
            owner_lsu_q     <= 1'b0;
            off_q           <= 2'd0;
            load_type_q     <= 3'd0;
            wen_q           <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_wdata_q     <= 32'd0;
            mem_wstrb_q     <= 4'd0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= 32'd0;
            lsu_rsp_data_q  <= 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            streak_q        <= streak_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        owner_lsu_q <= grant_lsu;
                        mem_addr_q  <= grant_lsu ? {lsu_addr_i[31:2], 2'b00} : {ifu_addr_i[31:2], 2'b00};
                        off_q       <= grant_lsu ? lsu_addr_i[1:0] : ifu_addr_i[1:0];
                        load_type_q <= grant_lsu ? lsu_load_type_i : 3'd0;
                        wen_q       <= grant_lsu && lsu_wen_i;
                        mem_wstrb_q <= (grant_lsu && lsu_wen_i) ?
                                       store_strb(lsu_store_type_i, lsu_addr_i[1:0]) : 4'd0;
                        mem_wdata_q <= (grant_lsu && lsu_wen_i) ?
                                       store_data(lsu_store_type_i, lsu_wdata_i) : 32'd0;
                        state_q     <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        ifu_rsp_valid_q <= ~owner_lsu_q;
                        lsu_rsp_valid_q <= owner_lsu_q;
                        if (owner_lsu_q) begin
                            lsu_rsp_data_q <= wen_q ? 32'd0 : load_extend(load_type_q, off_q, mem_rsp_data_i);
                        end else begin
                            ifu_rsp_data_q <= mem_rsp_data_i;
                        end
                        state_q <= ST_IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == TO_LAST) begin
                        ifu_rsp_valid_q <= ~owner_lsu_q;
                        lsu_rsp_valid_q <= owner_lsu_q;
                        if (owner_lsu_q) begin
                            lsu_rsp_data_q <= 32'hDEAD_BEEF;
                        end else begin
                            ifu_rsp_data_q <= 32'hDEAD_BEEF;
                        end
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                        state_q    <= ST_WAIT;
                    end
`else
                    else begin
                        state_q <= ST_WAIT;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ifu_req_ready_o = grant_ifu;
    assign lsu_req_ready_o = grant_lsu;
    assign ifu_rsp_valid_o = ifu_rsp_valid_q;
    assign ifu_rsp_data_o  = ifu_rsp_data_q;
    assign lsu_rsp_valid_o = lsu_rsp_valid_q;
    assign lsu_rsp_data_o  = lsu_rsp_data_q;
    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_addr_o      = mem_addr_q;
    assign mem_wen_o       = wen_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wstrb_o     = mem_wstrb_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_o       = timeout_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int MAX = 4;
    localparam logic [2:0] LOAD_NONE = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3, LD = 3'd4;
    localparam logic [2:0] LBU = 3'd5, LHU = 3'd6, LWU = 3'd7;
    localparam logic [2:0] STORE_NONE = 3'd0, SB = 3'd1, SH = 3'd2, SW = 3'd3, SD = 3'd4;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
    logic [31:0] ifu_addr_i, ifu_rsp_data_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_rsp_valid_o;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rsp_data_o;
    logic [2:0]  lsu_load_type_i, lsu_store_type_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rsp_data_i;
    logic [3:0]  mem_wstrb_o;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        timeout_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int streak_m = 0;

    mem_port_arbiter #(
        .MAX_LSU_STREAK(MAX)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_data_o(ifu_rsp_data_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_load_type_i(lsu_load_type_i), .lsu_store_type_i(lsu_store_type_i),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .timeout_o(timeout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_strb(input logic [2:0] st, input logic [1:0] off);
        int unsigned v;
        case (st)
            SB:      v = 1 << off;
            SH:      v = (3 << off) % 16;
            SW, SD:  v = 15;
            default: v = 0;
        endcase
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] st, input logic [31:0] wd);
        case (st)
            SB:      return {24'd0, wd[7:0]} * 32'h0101_0101;
            SH:      return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (lt)
            LB:      return (b >= 32'd128) ? b - 32'd256 : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valids"}, {27'd0, ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o,
                               lsu_rsp_valid_o, mem_req_valid_o}, 32'd0);
        chk({tag, "_ifu_data"}, ifu_rsp_data_o, 32'd0);
        chk({tag, "_lsu_data"}, lsu_rsp_data_o, 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_wen_strb"}, {27'd0, mem_wen_o, mem_wstrb_o}, 32'd0);
    endtask

    // One complete transaction: offer, accept, bus handshake, response. Starts/ends at posedge+1 in IDLE.
    task automatic run_txn(input bit ifv, input bit lsv, input logic [31:0] iaddr, input logic [31:0] laddr,
                           input bit wen, input logic [31:0] wd, input logic [2:0] lt, input logic [2:0] st,
                           input logic [31:0] rword, input int rdy_dly, input int rsp_dly,
                           output logic [31:0] o_addr, output logic [3:0] o_strb,
                           output logic [31:0] o_wdata, output logic [31:0] o_rsp);
        bit          win_lsu, e_wen;
        logic [31:0] e_addr, e_rsp;
        logic [3:0]  e_strb;
        win_lsu = lsv && !(ifv && streak_m == MAX);
        if (win_lsu) streak_m = ifv ? ((streak_m < MAX) ? streak_m + 1 : MAX) : 0;
        else streak_m = 0;
        e_addr = (win_lsu ? laddr : iaddr) & 32'hFFFF_FFFC;
        e_wen  = win_lsu && wen;
        e_strb = e_wen ? m_strb(st, laddr[1:0]) : 4'd0;
        e_rsp  = !win_lsu ? rword : (wen ? 32'd0 : m_load(lt, laddr[1:0], rword));

        ifu_req_valid_i = ifv; ifu_addr_i = iaddr;
        lsu_req_valid_i = lsv; lsu_addr_i = laddr; lsu_wen_i = wen; lsu_wdata_i = wd;
        lsu_load_type_i = lt; lsu_store_type_i = st;
        @(negedge clk);
        chk("ifu_ready", {31'd0, ifu_req_ready_o}, {31'd0, !win_lsu});
        chk("lsu_ready", {31'd0, lsu_req_ready_o}, {31'd0, win_lsu});
        @(posedge clk); #1;
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        mem_req_ready_i = (rdy_dly == 0);
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_rsp_valid_i = 1'($urandom_range(0, 1));
            mem_rsp_data_i  = $urandom;
            @(negedge clk);
            chk("req_valid", {31'd0, mem_req_valid_o}, 32'd1);
            chk("req_addr", mem_addr_o, e_addr);
            chk("req_wen", {31'd0, mem_wen_o}, {31'd0, e_wen});
            chk("req_strb", {28'd0, mem_wstrb_o}, {28'd0, e_strb});
            if (e_wen) chk("req_wdata", mem_wdata_o, m_wdata(st, wd));
            chk("no_early_rsp", {30'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'd0);
            o_addr = mem_addr_o; o_strb = mem_wstrb_o; o_wdata = mem_wdata_o;
            @(posedge clk); #1;
            mem_req_ready_i = (k + 1 == rdy_dly);
        end
        mem_rsp_valid_i = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            @(negedge clk);
            chk("wait_req_low", {31'd0, mem_req_valid_o}, 32'd0);
            chk("wait_no_rsp", {30'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'd0);
            @(posedge clk); #1;
        end
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = rword;
        @(negedge clk);
        chk("wait_req_low", {31'd0, mem_req_valid_o}, 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = $urandom;
        @(negedge clk);
        chk("rsp_ifu_valid", {31'd0, ifu_rsp_valid_o}, {31'd0, !win_lsu});
        chk("rsp_lsu_valid", {31'd0, lsu_rsp_valid_o}, {31'd0, win_lsu});
        o_rsp = win_lsu ? lsu_rsp_data_o : ifu_rsp_data_o;
        chk("rsp_data", o_rsp, e_rsp);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_one_cycle", {30'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] oa, ow, orsp;
    logic [3:0]  os;
    string       pat;
    int          n;
    bit          exp_lsu;

    initial begin
        rst_n = 1'b0;
        ifu_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1; ifu_addr_i = 32'd0; lsu_addr_i = 32'd0;
        lsu_wen_i = 1'b0; lsu_wdata_i = 32'd0; lsu_load_type_i = LOAD_NONE; lsu_store_type_i = STORE_NONE;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b0, 32'h8000_0004, 32'd0, 1'b0, 32'd0, LOAD_NONE, STORE_NONE,
                32'h0010_0073, 0, 0, oa, os, ow, orsp);
        chk("fetch_addr", oa, 32'h8000_0004);
        chk("fetch_strb", {28'd0, os}, 32'd0);
        chk("fetch_rsp", orsp, 32'h0010_0073);

        // Contention: both requesters held valid, bus always ready and responding.
        pat = "LLLLILLLLI";
        ifu_addr_i = 32'h8000_0100; lsu_addr_i = 32'h8000_0200; lsu_wen_i = 1'b0; lsu_load_type_i = LW;
        ifu_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1;
        mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0;
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clk);
            chk("one_ready", {31'd0, ifu_req_ready_o & lsu_req_ready_o}, 32'd0);
            if (ifu_req_ready_o || lsu_req_ready_o) begin
                exp_lsu = (pat[n] == "L");
                chk($sformatf("grant%0d_lsu", n), {31'd0, lsu_req_ready_o}, {31'd0, exp_lsu});
                streak_m = exp_lsu ? ((streak_m < MAX) ? streak_m + 1 : MAX) : 0;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("contention_grants", n, 10);
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;

        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0013, 1'b1, 32'h0000_00AB, LOAD_NONE, SB,
                32'h5555_5555, 1, 1, oa, os, ow, orsp);
        chk("sb_strb", {28'd0, os}, 32'h8);
        chk("sb_wdata", ow, 32'hABAB_ABAB);
        chk("sb_rsp", orsp, 32'd0);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0012, 1'b1, 32'h0000_1234, LOAD_NONE, SH,
                32'h0, 0, 2, oa, os, ow, orsp);
        chk("sh_strb", {28'd0, os}, 32'hC);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0010, 1'b1, 32'hDEAD_C0DE, LOAD_NONE, SW,
                32'h0, 0, 0, oa, os, ow, orsp);
        chk("sw_strb", {28'd0, os}, 32'hF);
        chk("sw_rsp", orsp, 32'd0);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0023, 1'b1, 32'h1111_2222, LOAD_NONE, SH,
                32'h0, 0, 0, oa, os, ow, orsp);
        chk("sh_off3_strb", {28'd0, os}, 32'h8);

        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0021, 1'b0, 32'd0, LB, STORE_NONE, 32'h80FF_7F01, 0, 0, oa, os, ow, orsp);
        chk("lb_off1", orsp, 32'h0000_007F);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0022, 1'b0, 32'd0, LB, STORE_NONE, 32'h80FF_7F01, 0, 0, oa, os, ow, orsp);
        chk("lb_off2", orsp, 32'hFFFF_FFFF);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0023, 1'b0, 32'd0, LBU, STORE_NONE, 32'h80FF_7F01, 0, 0, oa, os, ow, orsp);
        chk("lbu_off3", orsp, 32'h0000_0080);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0022, 1'b0, 32'd0, LH, STORE_NONE, 32'h80FF_7F01, 0, 0, oa, os, ow, orsp);
        chk("lh_off2", orsp, 32'hFFFF_80FF);
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0020, 1'b0, 32'd0, LHU, STORE_NONE, 32'h80FF_7F01, 0, 0, oa, os, ow, orsp);
        chk("lhu_off0", orsp, 32'h0000_7F01);

        // Five stalled REQ cycles: fields are compared against the model every cycle.
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0031, 1'b1, 32'h0000_00C3, LOAD_NONE, SB,
                32'h0, 5, 0, oa, os, ow, orsp);
        chk("stall_strb", {28'd0, os}, 32'h2);

        // Build streak to 3, then the next LSU win takes it to MAX and reset hits in WAIT.
        for (int i = 0; i < 3; i++)
            run_txn(1'b1, 1'b1, 32'h8000_1000, 32'h8000_2000, 1'b0, 32'd0, LW, STORE_NONE,
                    $urandom, 0, 0, oa, os, ow, orsp);
        ifu_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1; lsu_wen_i = 1'b0; lsu_load_type_i = LW;
        @(negedge clk);
        chk("pre_rst_lsu_ready", {31'd0, lsu_req_ready_o}, 32'd1);
        @(posedge clk); #1;
        lsu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1234_5678;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("wait_rst");
        @(posedge clk); #1;
        mem_rsp_valid_i = 1'b0; ifu_req_valid_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        streak_m = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_no_rsp", {30'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
        run_txn(1'b1, 1'b1, 32'h8000_3000, 32'h8000_4000, 1'b0, 32'd0, LW, STORE_NONE,
                32'hCAFE_F00D, 0, 0, oa, os, ow, orsp);
        chk("post_rst_grant_rsp", orsp, 32'hCAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            int sel;
            bit w;
            sel = $urandom_range(1, 3);
            w = 1'($urandom_range(0, 1));
            run_txn(sel[0], sel[1], $urandom, $urandom, w, $urandom, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 4)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    oa, os, ow, orsp);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        chk("timeout_init", {31'd0, timeout_o}, 32'd0);
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_5000;
        @(negedge clk);
        chk("to_ifu_ready", {31'd0, ifu_req_ready_o}, 32'd1);
        @(posedge clk); #1;
        ifu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; streak_m = 0;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("to_quiet%0d", k), {31'd0, ifu_rsp_valid_o}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_rsp_valid", {31'd0, ifu_rsp_valid_o}, 32'd1);
        chk("to_rsp_data", ifu_rsp_data_o, 32'hDEAD_BEEF);
        chk("to_flag", {31'd0, timeout_o}, 32'd1);
        @(posedge clk); #1;
        run_txn(1'b0, 1'b1, 32'd0, 32'h8000_6000, 1'b0, 32'd0, LW, STORE_NONE,
                32'h0BAD_F00D, 0, 1, oa, os, ow, orsp);
        chk("to_after_rsp", orsp, 32'h0BAD_F00D);
        chk("to_sticky", {31'd0, timeout_o}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the fetch stage (IF) and the load/store unit (LSU).
- Fixed priority with an anti-starvation limit; only one transaction is outstanding at a time.
- Builds write byte strobes from store_type_e on the way out.
- Aligns and extends load data from load_type_e on the way back.
- Sits between the IF/LSU stages and the memory bus adapter.

Parameters:
- MAX_LSU_STREAK, 4: consecutive LSU grants allowed while IF is waiting before IF is forced to win (range 1..15).
- TIMEOUT_CYCLES, 255: WAIT-state watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid_i  in  1  fetch request
- ifu_req_ready_o  out  1  fetch request accepted
- ifu_addr_i  in  32  fetch pc_t
- ifu_rsp_valid_o  out  1  fetch data valid (1-cycle pulse)
- ifu_rsp_data_o  out  32  fetched inst_t
- lsu_req_valid_i  in  1  LSU request
- lsu_req_ready_o  out  1  LSU request accepted
- lsu_addr_i  in  32  byte address
- lsu_wen_i  in  1  1 = store, 0 = load
- lsu_wdata_i  in  32  store data, LSB-aligned
- lsu_load_type_i  in  3  load_type_e
- lsu_store_type_i  in  3  store_type_e
- lsu_rsp_valid_o  out  1  LSU response pulse
- lsu_rsp_data_o  out  32  extended load data; 0 for stores
- mem_req_valid_o  out  1  bus request
- mem_req_ready_i  in  1  bus accepts request
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wen_o  out  1  write
- mem_wdata_o  out  32  lane-shifted write data
- mem_wstrb_o  out  4  byte strobes; 0 for reads
- mem_rsp_valid_i  in  1  bus response
- mem_rsp_data_i  in  32  read word

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, streak=0. All valid/ready outputs 0, all data outputs 0. An in-flight transaction is dropped and no response is issued.
- FSM states are IDLE, REQ and WAIT.
- IDLE, grant decision (combinational):
  - If both requesters are valid, LSU wins unless streak==MAX_LSU_STREAK, in which case IF wins.
  - Otherwise the single valid requester wins.
- IDLE, ready: ready is asserted only to the winner, combinationally, and only in IDLE. The loser's ready is 0.
- IDLE, accept: on valid&&ready, latch the owner, addr, wen, wdata, load_type and store_type. Next state is REQ.
- Streak counter:
  - On an LSU grant with ifu_req_valid_i=1, increment, saturating at MAX_LSU_STREAK.
  - On an LSU grant with IF idle, or on an IF grant, clear to 0.
- REQ: mem_req_valid_o=1 with the latched fields held stable. When mem_req_ready_i=1, next state is WAIT.
- WAIT: mem_req_valid_o=0. When mem_rsp_valid_i=1, next state is IDLE.
- Response return:
  - On the next cycle the owner's rsp_valid pulses for exactly 1 cycle with registered data.
  - A new grant is possible in that same response cycle.
- Minimum latency: accept at edge 0, REQ in cycle 1, WAIT in cycle 2. With the bus responding in cycle 2, rsp_valid appears in cycle 3.
- Responses have no backpressure; the consumer must accept.
- mem_rsp_valid_i outside WAIT is ignored.
- IF transactions are always reads: wstrb=0, and the response data is the raw word.
- Store strobes (off = addr[1:0]):
  - SB: strobe 0001<<off, wdata = {4{wdata[7:0]}}.
  - SH: strobe (0011<<off) truncated to 4 bits, wdata = {2{wdata[15:0]}}.
  - SW/SD: strobe 1111, wdata unchanged.
  - STORE_NONE with wen=1: strobe 0000; the bus write is still issued.
  - Misaligned stores are not trapped; truncation applies. Example: SH at off=3 gives strobe 1000.
- Load data (uses the latched off):
  - LB/LBU: byte at off*8, sign- or zero-extended.
  - LH/LHU: halfword at off[1]*16, sign- or zero-extended. off[0] is ignored.
  - LW/LD/LWU/LOAD_NONE: raw word.
- Store response: lsu_rsp_valid_o pulses with data 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds a WAIT-cycle counter and output port timeout_o (1 bit, sticky, reset 0).
  - If the counter reaches TIMEOUT_CYCLES without mem_rsp_valid_i, the owner's rsp_valid pulses with data 32'hDEAD_BEEF, timeout_o is set to 1, and the FSM returns to IDLE.
  - The counter clears on entry to WAIT.
  - A response arriving in the expiry cycle takes precedence over the timeout.
- When undefined: no counter, no timeout_o port, and WAIT holds indefinitely.

Test Plan:
- Single IF fetch, addr 0x8000_0004, bus ready immediately, rsp 0x0010_0073 in cycle 2 -> ifu_rsp_valid_o=1 in cycle 3 with data 0x0010_0073, mem_wstrb_o=0, mem_addr_o=0x8000_0004.
- Contention: IF and LSU held valid continuously, MAX_LSU_STREAK=4 -> grant order L,L,L,L,I,L,L,L,L,I; ready is never asserted to both in the same cycle.
- Stores: SB addr 0x8000_0013 wdata 0xAB -> strb 1000, wdata 0xABAB_ABAB. SH addr 0x8000_0012 -> strb 1100. SW -> 1111. The store response carries data 0.
- Loads: rsp word 0x80FF_7F01. LB off=1 -> 0x0000_007F. LB off=2 -> 0xFFFF_FFFF. LBU off=3 -> 0x0000_0080. LH off=2 -> 0xFFFF_80FF. LHU off=0 -> 0x0000_7F01.
- Stall and reset: mem_req_ready_i=0 for 5 cycles -> request fields stay stable throughout. Then assert rst_n=0 in WAIT -> all outputs are 0 immediately, no rsp pulse, streak=0, and after release a new request is granted from IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no bus response -> rsp pulse with 0xDEAD_BEEF after 8 WAIT cycles, timeout_o=1 and stays set, next request proceeds normally.
